// File: rtl/led_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_frame_pkg: shared state encodings and frame constants            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package led_frame_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_SOF     = 4'd1,
        ST_FETCH   = 4'd2,
        ST_CAPTURE = 4'd3,
        ST_HDR     = 4'd4,
        ST_BLUE    = 4'd5,
        ST_GREEN   = 4'd6,
        ST_RED     = 4'd7,
        ST_EOF     = 4'd8,
        ST_DONE    = 4'd9
    } frame_state_t;

    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_REQ  = 2'd1,
        HS_HOLD = 2'd2
    } hs_state_t;

    localparam int         c_sof_bytes  = 4;
    localparam logic [7:0] c_sof_byte   = 8'h00;
    localparam logic [7:0] c_eof_byte   = 8'hFF;
    localparam logic [2:0] c_hdr_prefix = 3'b111;

    // One 0xFF per 16 LEDs gives the strip enough extra clocks to flush.
    function automatic int end_bytes(input int num_leds);
        return (num_leds + 15) / 16;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_frame_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_frame_if: byte sender handshake and pixel store read port        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface led_frame_if #(
    parameter int ADDR_W = 3
);
    logic [7:0]        byte_out;
    logic              byte_start;
    logic              byte_busy;
    logic [ADDR_W-1:0] pix_addr;
    logic [23:0]       pix_data;

    modport master (
        output byte_out, byte_start, pix_addr,
        input  byte_busy, pix_data
    );

    modport slave (
        input  byte_out, byte_start, pix_addr,
        output byte_busy, pix_data
    );
endinterface
`default_nettype wire

// File: rtl/led_frame_byte_handshake.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | byte_handshake: one byte per send request over start/busy handshake  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module byte_handshake
    import led_frame_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_send,
    input  wire logic [7:0] i_data,
    input  wire logic       i_byte_busy,
    output logic [7:0]      o_byte_out,
    output logic            o_byte_start,
    output logic            o_sent
);

    hs_state_t  r_state;
    hs_state_t  w_next;
    logic [7:0] r_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= HS_IDLE;
            r_byte  <= 8'h00;
        end else begin
            r_state <= w_next;
            // The only point byte_out may change: no request pending, sender idle.
            if (r_state == HS_IDLE && i_send && !i_byte_busy)
                r_byte <= i_data;
        end
    end

    always_comb begin
        w_next = r_state;
        o_sent = 1'b0;
        case (r_state)
            HS_IDLE: if (i_send && !i_byte_busy) w_next = HS_REQ;
            HS_REQ:  if (i_byte_busy)            w_next = HS_HOLD;
            HS_HOLD: if (!i_byte_busy) begin
                w_next = HS_IDLE;
                o_sent = 1'b1;
            end
            default: w_next = HS_IDLE;
        endcase
    end

    assign o_byte_out   = r_byte;
    assign o_byte_start = (r_state == HS_REQ);

endmodule
`default_nettype wire

// File: rtl/led_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_frame: APA102 strip frame sequencer feeding the SPI byte sender  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module led_frame
    import led_frame_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int ADDR_W   = 3
) (
    input  wire logic       frame_clk,
    input  wire logic       frame_reset,
    input  wire logic       frame_start,
    input  wire logic [4:0] brightness,
    output logic            frame_busy,
    output logic            frame_done,
    led_frame_if.master     bus
);

    localparam int c_end_bytes = end_bytes(NUM_LEDS);
    localparam int c_cnt_max   = (c_end_bytes > c_sof_bytes) ? c_end_bytes : c_sof_bytes;
    localparam int c_cnt_w     = $clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_sof_last = c_cnt_w'(c_sof_bytes - 1);
    localparam logic [c_cnt_w-1:0] c_eof_last = c_cnt_w'(c_end_bytes - 1);
    localparam logic [ADDR_W-1:0]  c_led_last = ADDR_W'(NUM_LEDS - 1);

    frame_state_t       r_state;
    frame_state_t       w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [ADDR_W-1:0]  r_led;
    logic [ADDR_W-1:0]  r_pix_addr;
    logic [23:0]        r_pixel;
    logic [4:0]         r_bright;
    logic               w_send;
    logic [7:0]         w_data;
    logic               w_sent;

    byte_handshake u_hs (
        .clk          (frame_clk),
        .rst          (frame_reset),
        .i_send       (w_send),
        .i_data       (w_data),
        .i_byte_busy  (bus.byte_busy),
        .o_byte_out   (bus.byte_out),
        .o_byte_start (bus.byte_start),
        .o_sent       (w_sent)
    );

    always_ff @(posedge frame_clk) begin
        if (frame_reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_led      <= '0;
            r_pix_addr <= '0;
            r_pixel    <= '0;
            r_bright   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && frame_start) begin
                r_bright <= brightness;
                r_cnt    <= '0;
                r_led    <= '0;
            end
            // Counter is shared by SOF and EOF; clear it on every state change.
            if (w_sent)
                r_cnt <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
            if (r_state == ST_FETCH)
                r_pix_addr <= r_led;
            if (r_state == ST_CAPTURE)
                r_pixel <= bus.pix_data;
            if (r_state == ST_RED && w_sent && r_led != c_led_last)
                r_led <= r_led + 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        w_send = 1'b0;
        w_data = 8'h00;
        case (r_state)
            ST_IDLE:    if (frame_start) w_next = ST_SOF;
            ST_SOF: begin
                w_send = 1'b1;
                w_data = c_sof_byte;
                if (w_sent && r_cnt == c_sof_last) w_next = ST_FETCH;
            end
            ST_FETCH:   w_next = ST_CAPTURE;
            ST_CAPTURE: w_next = ST_HDR;
            ST_HDR: begin
                w_send = 1'b1;
                w_data = {c_hdr_prefix, r_bright};
                if (w_sent) w_next = ST_BLUE;
            end
            ST_BLUE: begin
                w_send = 1'b1;
                w_data = r_pixel[7:0];
                if (w_sent) w_next = ST_GREEN;
            end
            ST_GREEN: begin
                w_send = 1'b1;
                w_data = r_pixel[15:8];
                if (w_sent) w_next = ST_RED;
            end
            ST_RED: begin
                w_send = 1'b1;
                w_data = r_pixel[23:16];
                if (w_sent) w_next = (r_led == c_led_last) ? ST_EOF : ST_FETCH;
            end
            ST_EOF: begin
                w_send = 1'b1;
                w_data = c_eof_byte;
                if (w_sent && r_cnt == c_eof_last) w_next = ST_DONE;
            end
            ST_DONE:    w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    assign frame_busy   = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign frame_done   = (r_state == ST_DONE);
    assign bus.pix_addr = r_pix_addr;

endmodule
`default_nettype wire

// File: tb/tb_led_frame.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_frame: random pixels/brightness against a frame-level model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_led_frame;

    localparam int NUM_LEDS    = 17;
    localparam int ADDR_W      = 5;
    localparam int END_BYTES   = (NUM_LEDS + 15) / 16;
    localparam int FRAME_BYTES = 4 + 4 * NUM_LEDS + END_BYTES;

    logic       clk         = 1'b0;
    logic       rst         = 1'b1;
    logic       frame_start = 1'b0;
    logic [4:0] brightness  = 5'd0;
    logic       frame_busy;
    logic       frame_done;

    led_frame_if #(.ADDR_W(ADDR_W)) bus ();

    led_frame #(.NUM_LEDS(NUM_LEDS), .ADDR_W(ADDR_W)) dut (
        .frame_clk   (clk),
        .frame_reset (rst),
        .frame_start (frame_start),
        .brightness  (brightness),
        .frame_busy  (frame_busy),
        .frame_done  (frame_done),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  got_q [$];

    // Sender model: busy one cycle after start is seen, byte latched a cycle later.
    logic       sender_rst = 1'b1;
    bit         slow       = 1'b0;
    int         s_left     = 0;
    bit         s_latch    = 1'b0;
    logic [7:0] s_ref      = 8'h00;
    int         unstable   = 0;
    int         late_drop  = 0;

    always @(negedge clk) begin
        bus.pix_data = mem[bus.pix_addr];
        if (sender_rst) begin
            bus.byte_busy = 1'b0;
            s_left        = 0;
            s_latch       = 1'b0;
        end else if (bus.byte_busy) begin
            if (bus.byte_start) late_drop++;
            if (bus.byte_out !== s_ref) unstable++;
            if (s_latch) begin
                got_q.push_back(bus.byte_out);
                s_latch = 1'b0;
            end
            if (s_left == 0) bus.byte_busy = 1'b0;
            else s_left--;
        end else if (bus.byte_start) begin
            bus.byte_busy = 1'b1;
            s_ref         = bus.byte_out;
            s_latch       = 1'b1;
            s_left        = slow ? 39 : int'($urandom_range(0, 3));
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void randomize_pixels();
        for (int i = 0; i < 32; i++) mem[i] = 24'($urandom());
    endfunction

    // Whole frame as the strip sees it, straight from the frame layout rules.
    function automatic void build_exp(input logic [4:0] br);
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        for (int i = 0; i < NUM_LEDS; i++) begin
            exp_q.push_back({3'b111, br});
            exp_q.push_back(mem[i][7:0]);
            exp_q.push_back(mem[i][15:8]);
            exp_q.push_back(mem[i][23:16]);
        end
        for (int i = 0; i < END_BYTES; i++) exp_q.push_back(8'hFF);
    endfunction

    task automatic compare_stream(input string tag);
        check({tag, " byte count"}, got_q.size(), FRAME_BYTES);
        for (int i = 0; i < FRAME_BYTES; i++)
            if (i < got_q.size())
                check($sformatf("%s byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
    endtask

    task automatic start_frame(input logic [4:0] br);
        brightness  = br;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (frame_done !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, " frame_done before timeout"}, {31'd0, n < 20000}, 32'd1);
        @(negedge clk);
        check({tag, " frame_done one cycle"}, {31'd0, frame_done}, 32'd0);
        check({tag, " frame_busy low after"}, {31'd0, frame_busy}, 32'd0);
    endtask

    logic [4:0] br;

    initial begin
        randomize_pixels();
        repeat (3) @(negedge clk);
        check("reset frame_busy", {31'd0, frame_busy}, 32'd0);
        check("reset frame_done", {31'd0, frame_done}, 32'd0);
        check("reset byte_start", {31'd0, bus.byte_start}, 32'd0);
        check("reset byte_out", {24'd0, bus.byte_out}, 32'd0);
        check("reset pix_addr", {27'd0, bus.pix_addr}, 32'd0);
        rst        = 1'b0;
        sender_rst = 1'b0;
        @(negedge clk);

        // Frame 1: brightness changes mid-frame must not leak into headers.
        br = 5'($urandom_range(0, 31));
        build_exp(br);
        got_q.delete();
        start_frame(br);
        check("f1 busy after accept", {31'd0, frame_busy}, 32'd1);
        @(negedge clk);
        check("f1 first byte_start", {31'd0, bus.byte_start}, 32'd1);
        check("f1 first byte_out", {24'd0, bus.byte_out}, 32'd0);
        repeat (20) @(negedge clk);
        brightness = ~br;
        wait_done("f1");
        compare_stream("f1");
        check("f1 last pix_addr", {27'd0, bus.pix_addr}, NUM_LEDS - 1);

        // Frame 2: accepted in the cycle after frame_done, slow sender.
        randomize_pixels();
        br = 5'($urandom_range(0, 31));
        build_exp(br);
        got_q.delete();
        slow = 1'b1;
        start_frame(br);
        check("f2 restart accepted", {31'd0, frame_busy}, 32'd1);
        wait_done("f2");
        compare_stream("f2");

        // Frame 3: reset while LED 1 GREEN (byte index 10) is in flight.
        randomize_pixels();
        got_q.delete();
        start_frame(5'($urandom_range(0, 31)));
        begin
            int n = 0;
            while (got_q.size() < 11 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check("f3 reached LED1 GREEN", {31'd0, n < 5000}, 32'd1);
        end
        rst        = 1'b1;
        sender_rst = 1'b1;
        @(negedge clk);
        check("f3 reset byte_start", {31'd0, bus.byte_start}, 32'd0);
        check("f3 reset frame_busy", {31'd0, frame_busy}, 32'd0);
        check("f3 reset byte_out", {24'd0, bus.byte_out}, 32'd0);
        check("f3 reset frame_done", {31'd0, frame_done}, 32'd0);
        check("f3 reset pix_addr", {27'd0, bus.pix_addr}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        sender_rst = 1'b0;
        slow       = 1'b0;
        @(negedge clk);

        // Frame 4: fresh frame after reset, extra start pulse mid-frame.
        randomize_pixels();
        br = 5'($urandom_range(0, 31));
        build_exp(br);
        got_q.delete();
        start_frame(br);
        repeat (30) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        wait_done("f4");
        compare_stream("f4");
        repeat (20) @(negedge clk);
        check("f4 no queued frame bytes", got_q.size(), FRAME_BYTES);
        check("f4 no queued frame busy", {31'd0, frame_busy}, 32'd0);

        check("byte_out stable while busy", unstable, 32'd0);
        check("byte_start drops after busy", late_drop, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
